backscatter_pulse_gen: RTL and testbench
========================================

BACKSCATTER_PULSE_GEN -- requirements
Module: backscatter_pulse_gen

Interface
REQ-001 The block SHALL have parameter HP0, default 4, meaning clocks per half-period of the subcarrier for a 0 bit (HP0 >= 1).
REQ-002 The block SHALL have parameter HP1, default 2, meaning clocks per half-period of the subcarrier for a 1 bit (HP1 >= 1).
REQ-003 The block SHALL have parameter BIT_LEN, default 16, meaning clocks per transmitted bit (BIT_LEN >= 1).
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 data_in  input  8  byte to transmit, sent MSB first.
REQ-007 data_valid  input  1  data_in is valid.
REQ-008 data_ready  output  1  block can accept a byte.
REQ-009 abort  input  1  synchronous cancel of the current byte.
REQ-010 pulse  output  1  one-cycle toggle request to the downstream RF switch control (its pulse input).
REQ-011 busy  output  1  a byte is being transmitted.
REQ-012 done  output  1  one-cycle strobe when a byte completes normally.
REQ-013 bit_idx  output  3  index of the bit in flight: 0 is the MSB and 7 is the LSB.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-015 data_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in SEND.
REQ-016 Accept: data_valid && data_ready at an edge -> latch data_in into an 8-bit shift register, clear bit_timer, half_timer and bit_idx, enter SEND.
REQ-017 data_valid SHALL be ignored while in SEND; no byte is latched and none is queued.
REQ-018 Current half-period HP SHALL be HP1 if the shift register MSB is 1, else HP0.
REQ-019 half_timer SHALL count 0..HP-1 in SEND; at HP-1 it wraps to 0 and pulse is registered high for the next cycle only.
REQ-020 bit_timer SHALL count 0..BIT_LEN-1 in SEND; at BIT_LEN-1 it wraps to 0, the shift register shifts left 1, bit_idx increments, and half_timer clears to 0.
REQ-021 Simultaneous half_timer wrap and bit end SHALL still produce the pulse; the new bit's HP applies from the next cycle.
REQ-022 Bit end with bit_idx = 7 SHALL return to IDLE, assert done for one cycle and clear bit_idx to 0 (no 3-bit wrap is ever observable mid-byte).
REQ-023 Latency: byte accepted at edge T -> first pulse high in cycle T+1+HP (HP of the MSB); SEND lasts exactly 8*BIT_LEN cycles.
REQ-024 A new byte SHALL be accepted no earlier than the first edge after return to IDLE, giving a one-cycle inter-byte gap.
REQ-025 abort in SEND SHALL go to IDLE at that edge, force pulse to 0 in the following cycle, clear all timers and bit_idx, and leave done at 0; abort in IDLE has no effect.
REQ-026 abort SHALL have priority over a bit end and over a half_timer wrap in the same cycle.
REQ-027 pulse SHALL never be high in IDLE except the single registered cycle following a wrap that occurred on the final SEND cycle.
REQ-028 Every timer SHALL be wide enough for its largest parameter value, and comparisons SHALL not truncate.

Reset
REQ-029 While rst = 1, independent of CLK: state = IDLE, pulse = 0, done = 0, busy = 0, data_ready = 1, bit_idx = 0, timers = 0, shift register = 0.
REQ-030 Reset asserted mid-byte SHALL discard the byte; after release, the block waits in IDLE for a new accept.

Verification
REQ-031 HP0=4, HP1=2, BIT_LEN=16; send 0xA5 -> exactly 48 pulses (8 per 1-bit, 4 per 0-bit), busy high for 128 cycles, one done.
REQ-032 Send 0xFF -> 64 pulses spaced 2 cycles apart with uniform spacing across bit boundaries; first pulse in cycle T+3.
REQ-033 HP0=3, BIT_LEN=16, send 0x00 -> pulse spacing resets at each bit boundary: 5 pulses per bit, 40 in total.
REQ-034 data_valid held high with changing data_in during SEND -> no effect; next byte accepted one cycle after done.
REQ-035 abort asserted at bit_idx = 3 -> IDLE at that edge, no further pulses, done stays 0, data_ready = 1 next cycle.
REQ-036 rst pulsed asynchronously mid-bit -> outputs go to reset values immediately; a subsequent 0x80 transmits correctly (8 pulses in bit 0, then 4 per bit).

Source files
------------

// File: rtl/backscatter_pulse_gen.sv
// Backscatter subcarrier pulse generator: serialises one byte MSB first as FM0-style toggle requests.
// Latency: byte accepted at edge T -> first pulse in cycle T+1+HP(MSB); SEND lasts 8*BIT_LEN cycles.
// Backpressure: data_ready is high only in IDLE; data_valid is ignored (never queued) while sending.
//
// Ports:
//   CLK, rst          single clock, asynchronous active-high reset
//   data_in[7:0]      byte to send (MSB first), qualified by data_valid
//   data_ready        high while IDLE (byte can be accepted)
//   abort             synchronous cancel of the byte in flight
//   pulse             one-cycle toggle request to the RF switch control
//   busy              high while a byte is in flight
//   done              one-cycle strobe on normal byte completion
//   bit_idx[2:0]      bit in flight, 0 = MSB .. 7 = LSB
module backscatter_pulse_gen #(
  parameter int HP0     = 4,
  parameter int HP1     = 2,
  parameter int BIT_LEN = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       abort,
  output logic       pulse,
  output logic       busy,
  output logic       done,
  output logic [2:0] bit_idx
);

  // Timers sized for the largest count each must hold (minimum 1 bit).
  localparam int HP_MAX = (HP0 > HP1) ? HP0 : HP1;
  localparam int HW     = (HP_MAX  > 1) ? $clog2(HP_MAX)  : 1;
  localparam int BW     = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;

  localparam logic [HW-1:0] HP0_LAST = HW'(HP0 - 1);
  localparam logic [HW-1:0] HP1_LAST = HW'(HP1 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [BW-1:0] bit_timer_q, bit_timer_d;
  logic [HW-1:0] half_timer_q, half_timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;

  logic [HW-1:0] hp_last;
  logic          half_wrap;
  logic          bit_end;

  // Half-period follows the bit currently at the head of the shift register.
  assign hp_last   = sr_q[7] ? HP1_LAST : HP0_LAST;
  assign half_wrap = (half_timer_q == hp_last);
  assign bit_end   = (bit_timer_q == BIT_LAST);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_timer_q  <= '0;
      half_timer_q <= '0;
      bit_idx_q    <= '0;
      pulse_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_timer_q  <= bit_timer_d;
      half_timer_q <= half_timer_d;
      bit_idx_q    <= bit_idx_d;
      pulse_q      <= pulse_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_timer_d  = bit_timer_q;
    half_timer_d = half_timer_q;
    bit_idx_d    = bit_idx_q;
    pulse_d      = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d      = SEND;
          sr_d         = data_in;
          bit_timer_d  = '0;
          half_timer_d = '0;
          bit_idx_d    = '0;
        end
      end

      SEND: begin
        if (abort) begin
          // Abort outranks both the half-period wrap and the bit end.
          state_d      = IDLE;
          bit_timer_d  = '0;
          half_timer_d = '0;
          bit_idx_d    = '0;
        end else begin
          pulse_d      = half_wrap;
          half_timer_d = half_wrap ? '0 : half_timer_q + 1'b1;
          if (bit_end) begin
            // Bit boundary restarts the subcarrier phase; a wrap on this
            // same cycle has already produced its pulse above.
            bit_timer_d  = '0;
            half_timer_d = '0;
            sr_d         = {sr_q[6:0], 1'b0};
            if (bit_idx_q == 3'd7) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            bit_timer_d = bit_timer_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q == SEND);
  assign pulse      = pulse_q;
  assign done       = done_q;
  assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_backscatter_pulse_gen.sv
module tb_backscatter_pulse_gen;

  localparam int BL = 16;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;   // 0: default instance, 1: HP0=3 instance

  logic       dv0, dv1, ab0, ab1;
  logic       rdy0, rdy1, pulse0, pulse1, busy0, busy1, done0, done1;
  logic [2:0] idx0, idx1;

  assign dv0 = data_valid & ~sel;
  assign dv1 = data_valid &  sel;
  assign ab0 = abort & ~sel;
  assign ab1 = abort &  sel;

  backscatter_pulse_gen #(.HP0(4), .HP1(2), .BIT_LEN(BL)) u0 (
    .CLK(CLK), .rst(rst), .data_in(data_in), .data_valid(dv0), .data_ready(rdy0),
    .abort(ab0), .pulse(pulse0), .busy(busy0), .done(done0), .bit_idx(idx0)
  );

  backscatter_pulse_gen #(.HP0(3), .HP1(2), .BIT_LEN(BL)) u1 (
    .CLK(CLK), .rst(rst), .data_in(data_in), .data_valid(dv1), .data_ready(rdy1),
    .abort(ab1), .pulse(pulse1), .busy(busy1), .done(done1), .bit_idx(idx1)
  );

  logic       o_rdy, o_pulse, o_busy, o_done;
  logic [2:0] o_idx;
  assign o_rdy   = sel ? rdy1   : rdy0;
  assign o_pulse = sel ? pulse1 : pulse0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
  assign o_idx   = sel ? idx1   : idx0;

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit       sel;
    bit [7:0] data;
    int       pulses;
    int       bit0;
    int       first;
    int       min_gap;
    int       max_gap;
  } vec_t;

  vec_t vecs [8];

  // Per-byte measurements.
  int m_pulses, m_bit0, m_first, m_min, m_max, m_busy, m_done, m_rdy_at_done;

  task automatic accept(input bit [7:0] d);
    @(negedge CLK);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge CLK);
  endtask

  // Called just after the accept edge; k counts cycles after that edge.
  task automatic measure(input bit hold);
    int last;
    m_pulses = 0; m_bit0 = 0; m_first = 0; m_min = 999; m_max = 0;
    m_busy = 0; m_done = 0; m_rdy_at_done = 0; last = 0;
    for (int k = 1; k <= 8*BL + 4; k++) begin
      @(negedge CLK);
      if (hold) begin
        data_valid = 1'b1;
        data_in    = 8'($urandom);
      end else begin
        data_valid = 1'b0;
      end
      if (o_busy) m_busy++;
      if (o_pulse) begin
        m_pulses++;
        if (k <= BL + 1) m_bit0++;
        if (m_first == 0) m_first = k;
        else begin
          if (k - last < m_min) m_min = k - last;
          if (k - last > m_max) m_max = k - last;
        end
        last = k;
      end
      if (o_done) begin
        m_done++;
        m_rdy_at_done = int'(o_rdy);
        if (hold) begin
          data_in = 8'h00;   // byte that the next edge will accept
          break;
        end
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, int'(o_rdy),   1);
    chk({tag, "_busy"},  int'(o_busy),  0);
    chk({tag, "_pulse"}, int'(o_pulse), 0);
    chk({tag, "_done"},  int'(o_done),  0);
    chk({tag, "_idx"},   int'(o_idx),   0);
  endtask

  initial begin
    //          sel   data  pulses bit0 first min max
    vecs[0] = '{1'b0, 8'hA5, 48,   8,   3,    2,  4};
    vecs[1] = '{1'b0, 8'hFF, 64,   8,   3,    2,  2};
    vecs[2] = '{1'b0, 8'h00, 32,   4,   5,    4,  4};
    vecs[3] = '{1'b0, 8'h80, 36,   8,   3,    2,  4};
    vecs[4] = '{1'b0, 8'h01, 36,   4,   5,    2,  4};
    vecs[5] = '{1'b0, 8'h3C, 48,   4,   5,    2,  4};
    vecs[6] = '{1'b1, 8'h00, 40,   5,   4,    3,  4};
    vecs[7] = '{1'b1, 8'hFF, 64,   8,   3,    2,  2};

    // Reset state while rst is held.
    #12;
    sel = 1'b0; chk_idle_outputs("rst0");
    sel = 1'b1; chk_idle_outputs("rst1");
    sel = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    repeat (2) @(negedge CLK);

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      accept(vecs[i].data);
      measure(1'b0);
      chk($sformatf("v%0d_pulses", i),  m_pulses, vecs[i].pulses);
      chk($sformatf("v%0d_bit0", i),    m_bit0,   vecs[i].bit0);
      chk($sformatf("v%0d_first", i),   m_first,  vecs[i].first);
      chk($sformatf("v%0d_min_gap", i), m_min,    vecs[i].min_gap);
      chk($sformatf("v%0d_max_gap", i), m_max,    vecs[i].max_gap);
      chk($sformatf("v%0d_busy", i),    m_busy,   8*BL);
      chk($sformatf("v%0d_done", i),    m_done,   1);
    end
    sel = 1'b0;

    // data_valid held high with changing data during SEND; 0x00 queued at done.
    accept(8'hFF);
    measure(1'b1);
    chk("hold_pulses", m_pulses, 64);
    chk("hold_done", m_done, 1);
    chk("hold_rdy_at_done", m_rdy_at_done, 1);
    @(posedge CLK);          // edge right after the done cycle accepts 0x00
    measure(1'b0);
    chk("next_first", m_first, 5);
    chk("next_pulses", m_pulses, 32);
    chk("next_busy", m_busy, 8*BL);
    chk("next_done", m_done, 1);

    // Abort on the last cycle of bit 3, where a half wrap and bit end coincide.
    accept(8'hA5);
    begin
      int found = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge CLK);
        data_valid = 1'b0;
        if (o_idx == 3'd3) begin found = 1; break; end
      end
      chk("abort_reach_bit3", found, 1);
    end
    repeat (15) @(negedge CLK);
    chk("abort_pre_idx", int'(o_idx), 3);
    abort = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    abort = 1'b0;
    chk_idle_outputs("abort");
    begin
      int p = 0, d = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge CLK);
        if (o_pulse) p++;
        if (o_done) d++;
      end
      chk("abort_after_pulses", p, 0);
      chk("abort_after_done", d, 0);
    end

    // Asynchronous reset mid-bit, then 0x80 must send cleanly.
    accept(8'hFF);
    @(negedge CLK);
    data_valid = 1'b0;
    repeat (20) @(negedge CLK);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("arst");
    @(negedge CLK);
    rst = 1'b0;
    accept(8'h80);
    measure(1'b0);
    chk("post_rst_pulses", m_pulses, 36);
    chk("post_rst_bit0", m_bit0, 8);
    chk("post_rst_first", m_first, 3);
    chk("post_rst_done", m_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
